// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam logic PC_SRC_BRANCH = 1'b0;
  localparam logic PC_SRC_JUMP   = 1'b1;

  // Load-use bubble counter width; covers 1..7 stall cycles.
  localparam int unsigned LCNT_W = 3;

  // Enables and bubble inserts for the pipeline registers, MSB first.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN      = 8'b1111_0000;
  localparam pipe_ctl_t CTL_RESET    = 8'b0000_1111;
  localparam pipe_ctl_t CTL_FREEZE   = 8'b0000_0001;
  localparam pipe_ctl_t CTL_REDIRECT = 8'b1111_1110;
  localparam pipe_ctl_t CTL_LOAD_USE = 8'b0011_0100;

  function automatic logic is_taken(input logic branch, input logic flip,
                                    input logic jump, input logic zr);
    return (branch & (zr ^ flip)) | jump;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Status inputs from the ID/EX/MEM stages and the control outputs back to the pipeline.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              EX_MemRead;
  logic              EX_RegWrite;
  logic [ADDR_W-1:0] EX_reg_write_addr;
  logic              MEM_Branch;
  logic              MEM_BranchFlip;
  logic              MEM_Jump;
  logic              MEM_zr;
  logic              MEM_MemRead;
  logic              MEM_MemWrite;
  logic              mem_ready;

  logic              mem_req;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              memwb_flush;
  logic              redirect;
  logic              pc_src;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline datapath side.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           EX_MemRead, EX_RegWrite, EX_reg_write_addr,
           MEM_Branch, MEM_BranchFlip, MEM_Jump, MEM_zr,
           MEM_MemRead, MEM_MemWrite, mem_ready,
    input  mem_req, pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           redirect, pc_src, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           EX_MemRead, EX_RegWrite, EX_reg_write_addr,
           MEM_Branch, MEM_BranchFlip, MEM_Jump, MEM_zr,
           MEM_MemRead, MEM_MemWrite, mem_ready,
    output mem_req, pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           redirect, pc_src, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: memory-wait freeze, branch/jump redirect and load-use stall,
// with zero-latency control outputs and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W            = 32,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [LCNT_W-1:0] LSC       = LCNT_W'(LOAD_STALL_CYCLES);

  state_e            state_q, state_n;
  state_e            saved_q, saved_n;
  state_e            eff_state;
  logic [LCNT_W-1:0] lcnt_q, lcnt_n, lcnt_inc;

  logic      memop, taken, hazard;
  logic      mem_req_c, redirect_c, pc_src_c;
  logic      stall_inc, flush_inc;
  pipe_ctl_t ctl;

  assign memop  = bus.MEM_MemRead | bus.MEM_MemWrite;
  assign taken  = is_taken(bus.MEM_Branch, bus.MEM_BranchFlip, bus.MEM_Jump, bus.MEM_zr);
  assign hazard = bus.EX_MemRead & bus.EX_RegWrite & (bus.EX_reg_write_addr != ZERO_ADDR) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == bus.EX_reg_write_addr)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == bus.EX_reg_write_addr)));

  // While waiting on memory, decisions resume from the state that was interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
  assign lcnt_inc  = lcnt_q + LCNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      saved_q <= saved_n;
      lcnt_q  <= lcnt_n;
    end
  end

  // Priority: memory freeze, then redirect, then load-use.
  always_comb begin
    state_n    = eff_state;
    saved_n    = saved_q;
    lcnt_n     = lcnt_q;
    ctl        = CTL_RUN;
    mem_req_c  = 1'b0;
    redirect_c = 1'b0;
    pc_src_c   = PC_SRC_BRANCH;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (!rst_n) begin
      ctl = CTL_RESET;
    end else begin
      mem_req_c = memop | (state_q == MEM_WAIT);
      if (mem_req_c && !bus.mem_ready) begin
        ctl       = CTL_FREEZE;
        stall_inc = 1'b1;
        state_n   = MEM_WAIT;
        if (state_q != MEM_WAIT) begin
          saved_n = state_q;
        end
      end else if (taken) begin
        ctl        = CTL_REDIRECT;
        redirect_c = 1'b1;
        pc_src_c   = bus.MEM_Jump ? PC_SRC_JUMP : PC_SRC_BRANCH;
        flush_inc  = 1'b1;
        state_n    = RUN;
        saved_n    = RUN;
        lcnt_n     = '0;
      end else if (eff_state == LOAD_STALL) begin
        ctl       = CTL_LOAD_USE;
        stall_inc = 1'b1;
        if (lcnt_inc == LSC) begin
          state_n = RUN;
          lcnt_n  = '0;
        end else begin
          state_n = LOAD_STALL;
          lcnt_n  = lcnt_inc;
        end
      end else if (hazard) begin
        ctl       = CTL_LOAD_USE;
        stall_inc = 1'b1;
        if (LSC > LCNT_W'(1)) begin
          state_n = LOAD_STALL;
          lcnt_n  = LCNT_W'(1);
        end
      end
    end
  end

  assign bus.mem_req     = mem_req_c;
  assign bus.pc_en       = ctl.pc_en;
  assign bus.ifid_en     = ctl.ifid_en;
  assign bus.idex_en     = ctl.idex_en;
  assign bus.exmem_en    = ctl.exmem_en;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_flush  = ctl.idex_flush;
  assign bus.exmem_flush = ctl.exmem_flush;
  assign bus.memwb_flush = ctl.memwb_flush;
  assign bus.redirect    = redirect_c;
  assign bus.pc_src      = pc_src_c;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance with 1-cycle load stalls and 16-bit counters,
// one with 3-cycle load stalls and 4-bit counters for saturation.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [31:0] rs1, rs2;
    logic        use1, use2, ex_mr, ex_rw;
    logic [31:0] ex_rd;
    logic        br, flip, jmp, zr, mr, mw, rdy;
  } in_t;

  typedef struct {
    logic        rst;
    logic        dut;
    in_t         in;
    logic [10:0] ctl;
    logic [15:0] stall;
    logic [15:0] flush;
    int          id;
  } vec_t;

  // {mem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, redirect, pc_src}
  localparam logic [10:0] C_RST  = 11'b0_0000_1111_0_0;
  localparam logic [10:0] C_RUN  = 11'b0_1111_0000_0_0;
  localparam logic [10:0] C_LU   = 11'b0_0011_0100_0_0;
  localparam logic [10:0] C_BR   = 11'b0_1111_1110_1_0;
  localparam logic [10:0] C_JMP  = 11'b0_1111_1110_1_1;
  localparam logic [10:0] C_FRZ  = 11'b1_0000_0001_0_0;
  localparam logic [10:0] C_MRUN = 11'b1_1111_0000_0_0;
  localparam logic [10:0] C_MLU  = 11'b1_0011_0100_0_0;
  localparam logic [10:0] C_MJMP = 11'b1_1111_1110_1_1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  in_t  in_a  = '0;
  in_t  in_b  = '0;
  int   checks = 0;
  int   errors = 0;
  int   nvec   = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ADDR_W(32), .CNT_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.ADDR_W(32), .CNT_W(4))  ifb ();

  pipe_hazard_ctrl #(.ADDR_W(32), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  pipe_hazard_ctrl #(.ADDR_W(32), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.id_rs1 = in_a.rs1;             assign ifb.id_rs1 = in_b.rs1;
  assign ifa.id_rs2 = in_a.rs2;             assign ifb.id_rs2 = in_b.rs2;
  assign ifa.id_use_rs1 = in_a.use1;        assign ifb.id_use_rs1 = in_b.use1;
  assign ifa.id_use_rs2 = in_a.use2;        assign ifb.id_use_rs2 = in_b.use2;
  assign ifa.EX_MemRead = in_a.ex_mr;       assign ifb.EX_MemRead = in_b.ex_mr;
  assign ifa.EX_RegWrite = in_a.ex_rw;      assign ifb.EX_RegWrite = in_b.ex_rw;
  assign ifa.EX_reg_write_addr = in_a.ex_rd; assign ifb.EX_reg_write_addr = in_b.ex_rd;
  assign ifa.MEM_Branch = in_a.br;          assign ifb.MEM_Branch = in_b.br;
  assign ifa.MEM_BranchFlip = in_a.flip;    assign ifb.MEM_BranchFlip = in_b.flip;
  assign ifa.MEM_Jump = in_a.jmp;           assign ifb.MEM_Jump = in_b.jmp;
  assign ifa.MEM_zr = in_a.zr;              assign ifb.MEM_zr = in_b.zr;
  assign ifa.MEM_MemRead = in_a.mr;         assign ifb.MEM_MemRead = in_b.mr;
  assign ifa.MEM_MemWrite = in_a.mw;        assign ifb.MEM_MemWrite = in_b.mw;
  assign ifa.mem_ready = in_a.rdy;          assign ifb.mem_ready = in_b.rdy;

  logic [10:0] ctl_a, ctl_b;
  assign ctl_a = {ifa.mem_req, ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.ifid_flush,
                  ifa.idex_flush, ifa.exmem_flush, ifa.memwb_flush, ifa.redirect, ifa.pc_src};
  assign ctl_b = {ifb.mem_req, ifb.pc_en, ifb.ifid_en, ifb.idex_en, ifb.exmem_en, ifb.ifid_flush,
                  ifb.idex_flush, ifb.exmem_flush, ifb.memwb_flush, ifb.redirect, ifb.pc_src};

  function automatic in_t idle();
    in_t v = '0;
    return v;
  endfunction

  function automatic in_t lu(logic [31:0] rd, logic [31:0] r1, logic [31:0] r2,
                             logic u1, logic u2, logic rw);
    in_t v = '0;
    v.ex_mr = 1'b1; v.ex_rw = rw; v.ex_rd = rd;
    v.rs1 = r1; v.rs2 = r2; v.use1 = u1; v.use2 = u2;
    return v;
  endfunction

  function automatic in_t br(logic b, logic zr, logic flip, logic j);
    in_t v = '0;
    v.br = b; v.zr = zr; v.flip = flip; v.jmp = j;
    return v;
  endfunction

  function automatic in_t mem(logic rd, logic wr, logic rdy);
    in_t v = '0;
    v.mr = rd; v.mw = wr; v.rdy = rdy;
    return v;
  endfunction

  function automatic vec_t mk(logic rst, logic dut, in_t in, logic [10:0] ctl,
                              int stall, int flush);
    vec_t v;
    v.rst = rst; v.dut = dut; v.in = in; v.ctl = ctl;
    v.stall = 16'(stall); v.flush = 16'(flush); v.id = 0;
    return v;
  endfunction

  function automatic int sat(int x, int m);
    return (x > m) ? m : x;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue what it must produce.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst_n = !v.rst;
    in_a  = v.dut ? idle() : v.in;
    in_b  = v.dut ? v.in : idle();
    v.id  = nvec;
    nvec++;
    sb.push_back(v);
  endtask

  // Scoreboard: compare mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t        e;
      logic [10:0] ac;
      logic [15:0] as, af;
      e  = sb.pop_front();
      ac = e.dut ? ctl_b : ctl_a;
      as = e.dut ? 16'(ifb.stall_cnt) : ifa.stall_cnt;
      af = e.dut ? 16'(ifb.flush_cnt) : ifa.flush_cnt;
      checks += 3;
      if (ac !== e.ctl) begin
        errors++;
        $display("FAIL vec%0d dut%0d ctl: got %b expected %b", e.id, e.dut, ac, e.ctl);
      end
      if (as !== e.stall) begin
        errors++;
        $display("FAIL vec%0d dut%0d stall_cnt: got %0d expected %0d", e.id, e.dut, as, e.stall);
      end
      if (af !== e.flush) begin
        errors++;
        $display("FAIL vec%0d dut%0d flush_cnt: got %0d expected %0d", e.id, e.dut, af, e.flush);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;

    // Single-cycle load stall instance: reset, load-use, branches, memory wait.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, idle(), C_RST, 0, 0));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 0, 0));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 0, 0));
    tbl.push_back(mk(0, 0, lu(5, 0, 5, 0, 1, 1), C_LU, 0, 0));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 1, 0));
    tbl.push_back(mk(0, 0, lu(0, 0, 0, 1, 1, 1), C_RUN, 1, 0));
    tbl.push_back(mk(0, 0, lu(5, 5, 7, 0, 1, 1), C_RUN, 1, 0));
    tbl.push_back(mk(0, 0, lu(9, 9, 0, 1, 0, 1), C_LU, 1, 0));
    tbl.push_back(mk(0, 0, lu(5, 0, 5, 0, 1, 0), C_RUN, 2, 0));
    tbl.push_back(mk(0, 0, br(1, 0, 1, 0), C_BR, 2, 0));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 2, 1));
    tbl.push_back(mk(0, 0, br(1, 1, 1, 0), C_RUN, 2, 1));
    tbl.push_back(mk(0, 0, br(1, 1, 0, 0), C_BR, 2, 1));
    tbl.push_back(mk(0, 0, br(0, 0, 0, 1), C_JMP, 2, 2));
    tbl.push_back(mk(0, 0, in_t'(lu(5, 0, 5, 0, 1, 1) | br(1, 0, 1, 0)), C_BR, 2, 3));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 2, 4));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, mem(1, 0, 0), C_FRZ, 2 + i, 4));
    tbl.push_back(mk(0, 0, mem(1, 0, 1), C_MRUN, 6, 4));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 6, 4));
    tbl.push_back(mk(0, 0, mem(0, 1, 1), C_MRUN, 6, 4));
    tbl.push_back(mk(0, 0, in_t'(mem(1, 0, 0) | br(0, 0, 0, 1)), C_FRZ, 6, 4));
    tbl.push_back(mk(0, 0, in_t'(mem(1, 0, 1) | br(0, 0, 0, 1)), C_MJMP, 7, 4));
    tbl.push_back(mk(0, 0, idle(), C_RUN, 7, 5));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Three-cycle load stall, then a stall aborted by a redirect.
    step(mk(0, 1, lu(5, 0, 5, 0, 1, 1), C_LU, 0, 0));
    step(mk(0, 1, idle(), C_LU, 1, 0));
    step(mk(0, 1, idle(), C_LU, 2, 0));
    step(mk(0, 1, idle(), C_RUN, 3, 0));
    step(mk(0, 1, lu(5, 0, 5, 0, 1, 1), C_LU, 3, 0));
    step(mk(0, 1, idle(), C_LU, 4, 0));
    step(mk(0, 1, br(1, 0, 1, 0), C_BR, 5, 0));
    step(mk(0, 1, idle(), C_RUN, 5, 1));

    // Memory wait in the middle of a load stall resumes the stall afterwards.
    step(mk(0, 1, lu(5, 0, 5, 0, 1, 1), C_LU, 5, 1));
    step(mk(0, 1, mem(1, 0, 0), C_FRZ, 6, 1));
    step(mk(0, 1, mem(1, 0, 1), C_MLU, 7, 1));
    step(mk(0, 1, idle(), C_LU, 8, 1));
    step(mk(0, 1, idle(), C_RUN, 9, 1));

    // 4-bit counters run into all-ones and stay there.
    for (int i = 0; i < 8; i++) step(mk(0, 1, mem(1, 0, 0), C_FRZ, sat(9 + i, 15), 1));
    step(mk(0, 1, mem(1, 0, 1), C_MRUN, 15, 1));
    step(mk(0, 1, idle(), C_RUN, 15, 1));
    for (int i = 0; i < 16; i++) step(mk(0, 1, br(0, 0, 0, 1), C_JMP, 15, sat(1 + i, 15)));
    step(mk(0, 1, idle(), C_RUN, 15, 15));

    // Reset mid-stall leaves nothing pending.
    step(mk(0, 1, lu(5, 0, 5, 0, 1, 1), C_LU, 15, 15));
    step(mk(0, 1, idle(), C_LU, 15, 15));
    step(mk(1, 1, idle(), C_RST, 0, 0));
    step(mk(0, 1, idle(), C_RUN, 0, 0));
    step(mk(0, 1, idle(), C_RUN, 0, 0));
    step(mk(0, 0, idle(), C_RUN, 0, 0));

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
